// File: rtl/axil_csr_bank_if.sv
// AXI4-Lite control-port bundle (aw/w/b/ar/r) shared by the host side and the CSR bank.
// Pure wiring: no storage, no latency; ready/valid handshakes pass straight through.
interface axil_csr_bank_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64
);
  logic                   awvalid;
  logic                   awready;
  logic [ADDR_BITS-1:0]   awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  logic                   arvalid;
  logic                   arready;
  logic [ADDR_BITS-1:0]   araddr;
  logic                   rvalid;
  logic                   rready;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: write commits 1 cycle after AW+W are both held (B/ctrl_out/wr_pulse at T+2), reads answer at T+1.
// AW/W each have a one-entry holding slot; commit stalls while B is unacknowledged, AR stalls while R is pending.
module axil_csr_bank #(
  parameter int                N_REGS    = 16,
  parameter int                DATA_BITS = 64,
  parameter int                ADDR_BITS = 32,
  parameter logic [N_REGS-1:0] WR_MASK   = 'h0001,
  parameter logic [N_REGS-1:0] SC_MASK   = 'h0000
) (
  input  logic                 aclk,
  input  logic                 areset,
  axil_csr_bank_if.slave       axi_ctrl,
  input  logic [DATA_BITS-1:0] status_in [N_REGS],
  output logic [DATA_BITS-1:0] ctrl_out  [N_REGS],
  output logic [N_REGS-1:0]    wr_pulse,
  output logic [N_REGS-1:0]    rd_pulse
);
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int ADDR_LSB  = $clog2(STRB_BITS);
  // One index bit beyond the register count so that idx == N_REGS decodes as out of range.
  localparam int IDX_BITS  = $clog2(N_REGS + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IDX_BITS-1:0] idx_t;

  function automatic logic is_writable(idx_t idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == idx_t'(i)) r = WR_MASK[i];
    end
    return r;
  endfunction

  logic                 aw_held_q, aw_ok_q;
  idx_t                 aw_idx_q;
  logic                 w_held_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;
  logic                 bvalid_q;
  logic [1:0]           bresp_q;
  logic                 rvalid_q;
  logic [1:0]           rresp_q, rresp_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [DATA_BITS-1:0] regs_q [N_REGS];
  logic [DATA_BITS-1:0] regs_d [N_REGS];
  logic [N_REGS-1:0]    wr_pulse_q, wr_pulse_d;
  logic [N_REGS-1:0]    rd_pulse_q, rd_pulse_d;
  logic [DATA_BITS-1:0] wmask;

  idx_t aw_idx, ar_idx;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused_addr_bits;

  assign aw_idx = axi_ctrl.awaddr[ADDR_LSB +: IDX_BITS];
  assign ar_idx = axi_ctrl.araddr[ADDR_LSB +: IDX_BITS];
  assign unused_addr_bits = ^{axi_ctrl.awaddr, axi_ctrl.araddr};

  assign aw_hs  = axi_ctrl.awvalid && !aw_held_q;
  assign w_hs   = axi_ctrl.wvalid && !w_held_q;
  assign ar_hs  = axi_ctrl.arvalid && !rvalid_q;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  assign axi_ctrl.awready = !aw_held_q;
  assign axi_ctrl.wready  = !w_held_q;
  assign axi_ctrl.bvalid  = bvalid_q;
  assign axi_ctrl.bresp   = bresp_q;
  assign axi_ctrl.arready = !rvalid_q;
  assign axi_ctrl.rvalid  = rvalid_q;
  assign axi_ctrl.rdata   = rdata_q;
  assign axi_ctrl.rresp   = rresp_q;

  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

  always_comb begin
    for (int b = 0; b < STRB_BITS; b++) begin
      wmask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  // A commit takes priority over the self-clear; the two cannot overlap because B is still pending.
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      regs_d[i]     = regs_q[i];
      wr_pulse_d[i] = 1'b0;
      if (commit && aw_ok_q && (aw_idx_q == idx_t'(i))) begin
        regs_d[i]     = (regs_q[i] & ~wmask) | (wdata_q & wmask);
        wr_pulse_d[i] = 1'b1;
      end else if (SC_MASK[i] && wr_pulse_q[i]) begin
        regs_d[i] = '0;
      end
    end
  end

  always_comb begin
    rdata_d    = '0;
    rresp_d    = RESP_SLVERR;
    rd_pulse_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (ar_idx == idx_t'(i)) begin
        rresp_d       = RESP_OKAY;
        rdata_d       = WR_MASK[i] ? regs_q[i] : status_in[i];
        rd_pulse_d[i] = ar_hs;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      ctrl_out[i] = WR_MASK[i] ? regs_q[i] : '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_q  <= 1'b0;
      aw_ok_q    <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= aw_idx;
        aw_ok_q   <= (aw_idx < idx_t'(N_REGS)) && is_writable(aw_idx);
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end

      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= axi_ctrl.wdata;
        wstrb_q  <= axi_ctrl.wstrb;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
      end else if (axi_ctrl.bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (axi_ctrl.rready) begin
        rvalid_q <= 1'b0;
      end

      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed bench for axil_csr_bank: N_REGS=16, regs 0/1 writable, reg 1 self-clearing.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axil_csr_bank;
  logic        clk = 1'b0;
  logic        areset;
  logic [63:0] status_in [16];
  logic [63:0] ctrl_out  [16];
  logic [15:0] wr_pulse, rd_pulse;

  int n_asrt = 0;
  int n_fail = 0;
  int b_cnt  = 0;
  int wp0_cnt = 0;

  axil_csr_bank_if #(.ADDR_BITS(32), .DATA_BITS(64)) axi ();

  axil_csr_bank #(
    .N_REGS(16), .DATA_BITS(64), .ADDR_BITS(32),
    .WR_MASK(16'h0003), .SC_MASK(16'h0002)
  ) dut (
    .aclk(clk), .areset(areset), .axi_ctrl(axi),
    .status_in(status_in), .ctrl_out(ctrl_out),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!areset) begin
      if (axi.bvalid && axi.bready) b_cnt++;
      if (wr_pulse[0]) wp0_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [63:0] data,
                         output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    n = 0;
    do begin step(); n++; end while (!axi.rvalid && n < 20);
    axi.arvalid = 1'b0;
    chk("rd_latency", 64'(n), 64'd1);
    data  = axi.rdata;
    resp  = axi.rresp;
    pulse = rd_pulse;
    axi.rready = 1'b1;
    step();
    axi.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    axi.awvalid = 1'b1; axi.awaddr = addr;
    axi.wvalid  = 1'b1; axi.wdata  = data; axi.wstrb = strb;
    step();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 1;
    do begin step(); n++; end while (!axi.bvalid && n < 20);
    chk("wr_latency", 64'(n), 64'd2);
    resp  = axi.bresp;
    pulse = wr_pulse;
    axi.bready = 1'b1;
    step();
    axi.bready = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    logic [15:0] p;

    for (int i = 0; i < 16; i++) status_in[i] = 64'h5A00 + 64'(i);
    status_in[3] = 64'hDEAD_BEEF;
    areset = 1'b1;
    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready = 1'b0;
    repeat (3) step();
    areset = 1'b0;
    step();

    // Reset state
    chk("rst_awready", 64'(axi.awready), 64'd1);
    chk("rst_wready",  64'(axi.wready),  64'd1);
    chk("rst_arready", 64'(axi.arready), 64'd1);
    chk("rst_bvalid",  64'(axi.bvalid),  64'd0);
    chk("rst_rvalid",  64'(axi.rvalid),  64'd0);
    chk("rst_bresp",   64'(axi.bresp),   64'd0);
    chk("rst_rresp",   64'(axi.rresp),   64'd0);
    chk("rst_ctrl0",   ctrl_out[0],      64'd0);
    chk("rst_wr_pulse", 64'(wr_pulse),   64'd0);
    chk("rst_rd_pulse", 64'(rd_pulse),   64'd0);

    // Reads of a writable and a status register
    do_read(32'h00, d, r, p);
    chk("rd0_data", d, 64'd0);
    chk("rd0_resp", 64'(r), 64'd0);
    chk("rd0_pulse", 64'(p), 64'h0001);
    do_read(32'h18, d, r, p);
    chk("rd3_data", d, 64'hDEAD_BEEF);
    chk("rd3_resp", 64'(r), 64'd0);
    chk("rd3_pulse", 64'(p), 64'h0008);
    chk("rd_pulse_drop", 64'(rd_pulse), 64'd0);

    // Partial-strobe write, AW and W together
    axi.awvalid = 1'b1; axi.awaddr = 32'h00;
    axi.wvalid = 1'b1; axi.wdata = 64'h1122_3344_5566_7788; axi.wstrb = 8'h0F;
    step();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("w1_t1_awready", 64'(axi.awready), 64'd0);
    chk("w1_t1_bvalid",  64'(axi.bvalid),  64'd0);
    chk("w1_t1_ctrl0",   ctrl_out[0],      64'd0);
    step();
    chk("w1_t2_bvalid", 64'(axi.bvalid), 64'd1);
    chk("w1_t2_bresp",  64'(axi.bresp),  64'd0);
    chk("w1_t2_ctrl0",  ctrl_out[0],     64'h0000_0000_5566_7788);
    chk("w1_t2_pulse",  64'(wr_pulse),   64'h0001);
    axi.bready = 1'b1;
    step();
    axi.bready = 1'b0;
    chk("w1_t3_bvalid", 64'(axi.bvalid), 64'd0);
    chk("w1_t3_pulse",  64'(wr_pulse),   64'd0);
    chk("w1_t3_ctrl0",  ctrl_out[0],     64'h0000_0000_5566_7788);

    // W three cycles ahead of AW, then a second write queued behind a stalled B
    axi.wvalid = 1'b1; axi.wdata = 64'hAAAA_BBBB_CCCC_DDDD; axi.wstrb = 8'hFF;
    step();
    axi.wvalid = 1'b0;
    chk("w2_wready_held", 64'(axi.wready), 64'd0);
    chk("w2_awready_free", 64'(axi.awready), 64'd1);
    step();
    step();
    axi.awvalid = 1'b1; axi.awaddr = 32'h00;
    step();
    axi.awvalid = 1'b0;
    chk("w2_commit_bvalid", 64'(axi.bvalid), 64'd0);
    step();
    chk("w2_bvalid", 64'(axi.bvalid), 64'd1);
    chk("w2_ctrl0",  ctrl_out[0], 64'hAAAA_BBBB_CCCC_DDDD);
    chk("w2_pulse",  64'(wr_pulse), 64'h0001);
    axi.awvalid = 1'b1; axi.awaddr = 32'h00;
    step();
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = 64'h0123_4567_89AB_CDEF; axi.wstrb = 8'hF0;
    step();
    axi.wvalid = 1'b0;
    repeat (3) step();
    chk("w3_stall_bvalid",  64'(axi.bvalid),  64'd1);
    chk("w3_stall_ctrl0",   ctrl_out[0],      64'hAAAA_BBBB_CCCC_DDDD);
    chk("w3_stall_awready", 64'(axi.awready), 64'd0);
    chk("w3_stall_wready",  64'(axi.wready),  64'd0);
    chk("w3_stall_pulse",   64'(wr_pulse),    64'd0);
    axi.bready = 1'b1;
    step();
    axi.bready = 1'b0;
    chk("w3_b1_done", 64'(axi.bvalid), 64'd0);
    step();
    chk("w3_bvalid", 64'(axi.bvalid), 64'd1);
    chk("w3_bresp",  64'(axi.bresp),  64'd0);
    chk("w3_ctrl0",  ctrl_out[0],     64'h0123_4567_CCCC_DDDD);
    chk("w3_pulse",  64'(wr_pulse),   64'h0001);
    axi.bready = 1'b1;
    step();
    axi.bready = 1'b0;
    chk("w3_b2_done", 64'(axi.bvalid), 64'd0);

    // Illegal accesses
    do_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r, p);
    chk("ro_wr_bresp", 64'(r), 64'd2);
    chk("ro_wr_pulse", 64'(p), 64'd0);
    chk("ro_wr_ctrl2", ctrl_out[2], 64'd0);
    chk("ro_wr_ctrl0", ctrl_out[0], 64'h0123_4567_CCCC_DDDD);
    do_read(32'h80, d, r, p);
    chk("oor_rd_data",  d, 64'd0);
    chk("oor_rd_resp",  64'(r), 64'd2);
    chk("oor_rd_pulse", 64'(p), 64'd0);

    // Self-clearing register 1, read back in its pulse cycle and afterwards
    axi.awvalid = 1'b1; axi.awaddr = 32'h08;
    axi.wvalid = 1'b1; axi.wdata = 64'd5; axi.wstrb = 8'hFF;
    step();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    step();
    chk("sc_ctrl1",  ctrl_out[1], 64'd5);
    chk("sc_pulse",  64'(wr_pulse), 64'h0002);
    chk("sc_bvalid", 64'(axi.bvalid), 64'd1);
    axi.arvalid = 1'b1; axi.araddr = 32'h08;
    axi.bready = 1'b1;
    step();
    axi.arvalid = 1'b0; axi.bready = 1'b0;
    chk("sc_ctrl1_clear", ctrl_out[1], 64'd0);
    chk("sc_rd_rvalid",   64'(axi.rvalid), 64'd1);
    chk("sc_rd_data",     axi.rdata, 64'd5);
    chk("sc_rd_pulse",    64'(rd_pulse), 64'h0002);
    axi.rready = 1'b1;
    step();
    axi.rready = 1'b0;
    do_read(32'h08, d, r, p);
    chk("sc_rd_late", d, 64'd0);
    chk("sc_rd_late_resp", 64'(r), 64'd0);

    // Read of register 0 in the same cycle as its commit returns the old value
    axi.awvalid = 1'b1; axi.awaddr = 32'h00;
    axi.wvalid = 1'b1; axi.wdata = 64'hFFFF_FFFF_FFFF_FFFF; axi.wstrb = 8'h01;
    step();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.arvalid = 1'b1; axi.araddr = 32'h00;
    step();
    axi.arvalid = 1'b0;
    chk("rw_rd_data", axi.rdata, 64'h0123_4567_CCCC_DDDD);
    chk("rw_ctrl0",   ctrl_out[0], 64'h0123_4567_CCCC_DDFF);
    axi.bready = 1'b1; axi.rready = 1'b1;
    step();
    axi.bready = 1'b0; axi.rready = 1'b0;

    chk("total_b_responses", 64'(b_cnt), 64'd6);
    chk("total_wr_pulse0",   64'(wp0_cnt), 64'd4);

    // Reset with an AW held and an R response pending
    axi.awvalid = 1'b1; axi.awaddr = 32'h00;
    axi.arvalid = 1'b1; axi.araddr = 32'h18;
    step();
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    chk("mid_awready", 64'(axi.awready), 64'd0);
    chk("mid_rvalid",  64'(axi.rvalid),  64'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("ar_bvalid",  64'(axi.bvalid),  64'd0);
    chk("ar_rvalid",  64'(axi.rvalid),  64'd0);
    chk("ar_awready", 64'(axi.awready), 64'd1);
    chk("ar_wready",  64'(axi.wready),  64'd1);
    chk("ar_ctrl0",   ctrl_out[0],      64'd0);
    axi.wvalid = 1'b1; axi.wdata = 64'h77; axi.wstrb = 8'hFF;
    step();
    axi.wvalid = 1'b0;
    step();
    step();
    chk("ar_no_commit_bvalid", 64'(axi.bvalid), 64'd0);
    chk("ar_no_commit_ctrl0",  ctrl_out[0], 64'd0);
    chk("ar_no_extra_b", 64'(b_cnt), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
